// File: rtl/controle_medicao_periodica_pkg.sv
// pkg_medicao: shared definitions for controle_medicao_periodica.
//   estado_t      - sequencer states; the numeric code is exported on db_estado
//   BCD_W         - width of a 3-digit BCD distance {hundreds, tens, units}
//   CONFIRMACOES  - consecutive readings needed to change alarme when
//                   CONFIRMACAO_ALARME_EN is defined
package pkg_medicao;

    localparam int unsigned BCD_W        = 12;
    localparam int unsigned CONFIRMACOES = 3;

    typedef enum logic [3:0] {
        INICIAL  = 4'h0,
        DISPARA  = 4'h1,
        AGUARDA  = 4'h2,
        REGISTRA = 4'h3,
        ATUALIZA = 4'h4,
        ESPERA   = 4'h5,
        FALHA    = 4'hF
    } estado_t;

endpackage

// File: rtl/controle_medicao_periodica_contador.sv
// contador_intervalo: saturating up-counter with clear, enable and
// terminal-count flag (terminal when the count equals MODULO-1).
//   clock_i, reset_i - clock, synchronous active-high reset
//   limpar_i         - restart the count
//   contar_i         - count enable
//   terminal_o       - count has reached MODULO-1 (held there, never wraps)
module contador_intervalo #(
    parameter int unsigned MODULO = 16
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic limpar_i,
    input  logic contar_i,
    output logic terminal_o
);

    localparam int unsigned W = (MODULO > 1) ? $clog2(MODULO) : 1;
    localparam logic [W-1:0] ULTIMO = W'(MODULO - 1);

    logic [W-1:0] cont_q, cont_d;

    assign terminal_o = (cont_q == ULTIMO);

    always_comb begin
        cont_d = cont_q;
        if (limpar_i) begin
            // Clearing while enabled counts the clearing cycle as the first
            // tick, so the count equals cycles elapsed since the clear cycle.
            cont_d = contar_i ? W'(1) : '0;
        end else if (contar_i && !terminal_o) begin
            cont_d = cont_q + W'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) cont_q <= '0;
        else         cont_q <= cont_d;
    end

endmodule

// File: rtl/controle_medicao_periodica.sv
// controle_medicao_periodica: periodic measurement sequencer for the HC-SR04
// interface. Issues medir every PERIODO_MEDIDA cycles while ligar is high,
// waits for pronto_sensor under a TIMEOUT_PRONTO watchdog, latches the BCD
// reading into distancia and drives alarme against LIMIAR_BCD.
// Optional macro CONFIRMACAO_ALARME_EN: alarme changes only after
// CONFIRMACOES consecutive readings on the opposite side of the threshold.
// Ports:
//   clock, reset (sync, active-high), ligar (run level),
//   pronto_sensor (1-cycle valid pulse), medida_sensor (12-bit BCD),
//   medir (1-cycle request), distancia (last reading), nova_medida (update
//   pulse), alarme (proximity level), erro_timeout (sticky watchdog flag),
//   db_estado (state code).
module controle_medicao_periodica
    import pkg_medicao::*;
#(
    parameter int unsigned      PERIODO_MEDIDA = 5_000_000,
    parameter int unsigned      TIMEOUT_PRONTO = 3_000_000,
    parameter logic [BCD_W-1:0] LIMIAR_BCD     = 12'h020
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ligar,
    input  logic             pronto_sensor,
    input  logic [BCD_W-1:0] medida_sensor,
    output logic             medir,
    output logic [BCD_W-1:0] distancia,
    output logic             nova_medida,
    output logic             alarme,
    output logic             erro_timeout,
    output logic [3:0]       db_estado
);

    estado_t          estado_q, estado_d;
    logic [BCD_W-1:0] distancia_q;
    logic             alarme_q;
    logic             erro_q;
    logic             intervalo_fim, watchdog_fim;
    logic             captura, falha, abaixo;

    contador_intervalo #(.MODULO(PERIODO_MEDIDA)) u_intervalo (
        .clock_i    (clock),
        .reset_i    (reset),
        .limpar_i   (estado_q == DISPARA),
        .contar_i   (estado_q != INICIAL),
        .terminal_o (intervalo_fim)
    );

    contador_intervalo #(.MODULO(TIMEOUT_PRONTO)) u_watchdog (
        .clock_i    (clock),
        .reset_i    (reset),
        .limpar_i   (estado_q == DISPARA),
        .contar_i   ((estado_q == DISPARA) || (estado_q == AGUARDA)),
        .terminal_o (watchdog_fim)
    );

    // Reading and failure are registered on the transition out of AGUARDA,
    // so distancia/erro_timeout are already valid while in REGISTRA/FALHA.
    assign captura = (estado_q == AGUARDA) && pronto_sensor;
    assign falha   = (estado_q == AGUARDA) && !pronto_sensor && watchdog_fim;
    assign abaixo  = (medida_sensor < LIMIAR_BCD);  // BCD orders like binary

    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            INICIAL:  if (ligar) estado_d = DISPARA;
            DISPARA:  estado_d = AGUARDA;
            AGUARDA: begin
                if (pronto_sensor)     estado_d = REGISTRA;
                else if (watchdog_fim) estado_d = FALHA;
            end
            REGISTRA: estado_d = ATUALIZA;
            ATUALIZA: estado_d = ESPERA;
            ESPERA: begin
                if (!ligar)             estado_d = INICIAL;
                else if (intervalo_fim) estado_d = DISPARA;
            end
            FALHA:    estado_d = ESPERA;
            default:  estado_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) estado_q <= INICIAL;
        else       estado_q <= estado_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            distancia_q <= '0;
            erro_q      <= 1'b0;
        end else if (captura) begin
            distancia_q <= medida_sensor;
            erro_q      <= 1'b0;
        end else if (falha) begin
            erro_q      <= 1'b1;
        end
    end

`ifdef CONFIRMACAO_ALARME_EN
    // run_q counts consecutive readings disagreeing with the current alarme.
    logic [1:0] run_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            alarme_q <= 1'b0;
            run_q    <= '0;
        end else if (captura) begin
            if (abaixo != alarme_q) begin
                if (run_q == 2'(CONFIRMACOES - 1)) begin
                    alarme_q <= abaixo;
                    run_q    <= '0;
                end else begin
                    run_q    <= run_q + 2'd1;
                end
            end else begin
                run_q <= '0;
            end
        end else if (falha) begin
            run_q <= '0;
        end
    end
`else
    always_ff @(posedge clock) begin
        if (reset)        alarme_q <= 1'b0;
        else if (captura) alarme_q <= abaixo;
        else if (falha)   alarme_q <= 1'b0;
    end
`endif

    assign medir        = (estado_q == DISPARA);
    assign nova_medida  = (estado_q == ATUALIZA);
    assign distancia    = distancia_q;
    assign alarme       = alarme_q;
    assign erro_timeout = erro_q;
    assign db_estado    = estado_q;

endmodule

// File: tb/tb_controle_medicao_periodica.sv
module tb_controle_medicao_periodica;

    localparam int unsigned PER = 100;
    localparam int unsigned TMO = 50;
    localparam logic [11:0] LIM = 12'h020;

    logic        clock = 1'b0;
    logic        reset;
    logic        ligar;
    logic        pronto_sensor;
    logic [11:0] medida_sensor;
    logic        medir;
    logic [11:0] distancia;
    logic        nova_medida;
    logic        alarme;
    logic        erro_timeout;
    logic [3:0]  db_estado;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [11:0] exp_dist;
    logic        exp_alarm;
    logic        exp_erro;
    bit          hist[$];

    controle_medicao_periodica #(
        .PERIODO_MEDIDA (PER),
        .TIMEOUT_PRONTO (TMO),
        .LIMIAR_BCD     (LIM)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ligar         (ligar),
        .pronto_sensor (pronto_sensor),
        .medida_sensor (medida_sensor),
        .medir         (medir),
        .distancia     (distancia),
        .nova_medida   (nova_medida),
        .alarme        (alarme),
        .erro_timeout  (erro_timeout),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int bcd2int(input logic [11:0] v);
        return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [11:0] rand_bcd();
        logic [11:0] v;
        if ($urandom_range(0, 1) == 0)
            v = {4'd0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 9))};
        else
            v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        return v;
    endfunction

    task automatic model_leitura(input logic [11:0] v);
        bit below;
        below    = bcd2int(v) < bcd2int(LIM);
        exp_dist = v;
        exp_erro = 1'b0;
`ifdef CONFIRMACAO_ALARME_EN
        hist.push_back(below);
        if (hist.size() >= 3) begin
            if (hist[$] == hist[$-1] && hist[$-1] == hist[$-2] && below != exp_alarm) begin
                exp_alarm = below;
                hist.delete();
            end
        end
`else
        exp_alarm = below;
`endif
    endtask

    task automatic model_falha();
        exp_erro = 1'b1;
`ifdef CONFIRMACAO_ALARME_EN
        hist.delete();
`else
        exp_alarm = 1'b0;
`endif
    endtask

    task automatic model_reset();
        exp_dist  = '0;
        exp_alarm = 1'b0;
        exp_erro  = 1'b0;
        hist.delete();
    endtask

    task automatic chk_saidas(input string tag);
        chk({tag, "_dist"},   distancia,    exp_dist);
        chk({tag, "_alarme"}, alarme,       exp_alarm);
        chk({tag, "_erro"},   erro_timeout, exp_erro);
    endtask

    // Entered in the window where medir must be high; for a normal episode
    // leaves in the window of the next expected medir (PER cycles later).
    // atraso >= TMO means the bench lets the watchdog expire; a pronto is
    // still pulsed at window atraso (if < PER) and must be ignored.
    task automatic episodio(input int atraso, input logic [11:0] valor, input bit soltar);
        int fim;
        bit ok;
        ok  = (atraso < int'(TMO));
        fim = soltar ? int'(PER) + 10 : int'(PER) - 1;
        chk("medir_pulso", medir, 1);
        chk("estado_dispara", db_estado, 4'h1);
        for (int w = 1; w <= fim; w++) begin
            tick();
            pronto_sensor = 1'b0;
            medida_sensor = rand_bcd();
            if (soltar && w == 1) ligar = 1'b0;
            chk("medir_zero", medir, 0);
            if (ok) begin
                if (w <= atraso) begin
                    chk("estado_aguarda", db_estado, 4'h2);
                end else if (w == atraso + 1) begin
                    model_leitura(valor);
                    chk("estado_registra", db_estado, 4'h3);
                    chk_saidas("registra");
                    chk("nova_antes", nova_medida, 0);
                end else if (w == atraso + 2) begin
                    chk("nova_pulso", nova_medida, 1);
                    chk("estado_atualiza", db_estado, 4'h4);
                end else if (w == atraso + 3) begin
                    chk("nova_fim", nova_medida, 0);
                    chk("estado_espera", db_estado, 4'h5);
                end else begin
                    chk("estado_pos", db_estado, soltar ? 32'h0 : 32'h5);
                end
            end else begin
                if (w < int'(TMO)) begin
                    chk("estado_aguarda_t", db_estado, 4'h2);
                    chk("erro_antes", erro_timeout, exp_erro);
                end else if (w == int'(TMO)) begin
                    model_falha();
                    chk("estado_falha", db_estado, 4'hF);
                    chk_saidas("falha");
                end else if (w == int'(TMO) + 1) begin
                    chk("estado_pos_falha", db_estado, 4'h5);
                end else begin
                    chk("estado_pos_t", db_estado, soltar ? 32'h0 : 32'h5);
                    chk_saidas("apos_falha");
                    chk("nova_ign", nova_medida, 0);
                end
            end
            if (w == atraso) begin
                pronto_sensor = 1'b1;
                medida_sensor = valor;
            end
        end
        if (!soltar) tick();
    endtask

    initial begin
        reset = 1'b1;
        ligar = 1'b0;
        pronto_sensor = 1'b0;
        medida_sensor = '0;
        model_reset();

        tick(); tick(); tick();
        chk("rst_estado", db_estado, 4'h0);
        chk("rst_medir", medir, 0);
        chk("rst_nova", nova_medida, 0);
        chk_saidas("rst");
        reset = 1'b0;
        tick(); tick();
        chk("ocioso", db_estado, 4'h0);
        chk("ocioso_medir", medir, 0);
        ligar = 1'b1;
        tick();

        episodio(5, 12'h123, 0);
        episodio(55, 12'h077, 0);      // no valid pronto: watchdog failure
        episodio(7, 12'h050, 0);       // success clears erro_timeout
        episodio(3, 12'h015, 0);
        episodio(4, 12'h019, 0);
        episodio(6, 12'h025, 0);
        episodio(2, 12'h020, 0);       // exactly at threshold: not closer
        episodio(3, 12'h015, 0);
        episodio(3, 12'h015, 0);
        episodio(3, 12'h015, 0);
        episodio(3, 12'h025, 0);
        episodio(3, 12'h015, 0);
        episodio(49, 12'h042, 0);      // pronto with watchdog terminal count
        for (int i = 0; i < 12; i++)
            episodio(int'($urandom_range(1, 60)), rand_bcd(), 0);
        episodio(10, 12'h015, 0);
        episodio(60, 12'h011, 0);

        // reset in the middle of AGUARDA
        tick(); tick(); tick();
        chk("pre_rst_estado", db_estado, 4'h2);
        reset = 1'b1;
        tick();
        model_reset();
        chk("rst2_estado", db_estado, 4'h0);
        chk("rst2_medir", medir, 0);
        chk("rst2_nova", nova_medida, 0);
        chk_saidas("rst2");
        reset = 1'b0;
        tick();

        episodio(8, 12'h031, 1);       // ligar dropped during AGUARDA
        chk("final_ocioso", db_estado, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/controle_medicao_periodica.md
Name: controle_medicao_periodica

Overview:
- Sequencer for the HC-SR04 interface block: issues periodic `medir` requests, waits for `pronto` under a watchdog, and latches each completed reading.
- Compares each reading against a proximity threshold to drive `alarme`.
- Sits between the top-level application FSM and the sensor interface; the interface is the only resource it drives.

Parameters:
- PERIODO_MEDIDA, 5_000_000, cycles between consecutive `medir` requests, counted from request issue (100 ms at 50 MHz).
- TIMEOUT_PRONTO, 3_000_000, cycles allowed from `medir` to `pronto_sensor` before a failure is declared.
- LIMIAR_BCD, 12'h020, alarm threshold as 3-digit BCD (020 cm).

Ports:
- clock, in, 1, system clock.
- reset, in, 1, synchronous, active-high.
- ligar, in, 1, level; 1 = run periodic measurements, 0 = stop after the current measurement completes.
- pronto_sensor, in, 1, 1-cycle pulse from the interface; `medida_sensor` is valid in the same cycle.
- medida_sensor, in, 12, 3-digit BCD distance {hundreds, tens, units}.
- medir, out, 1, 1-cycle request pulse to the interface.
- distancia, out, 12, last valid BCD reading.
- nova_medida, out, 1, 1-cycle pulse when `distancia` updates.
- alarme, out, 1, level; 1 = object closer than LIMIAR_BCD.
- erro_timeout, out, 1, sticky watchdog failure flag.
- db_estado, out, 4, current state code.

Behaviour:
- Reset (synchronous, active-high, overrides everything, including mid-measurement):
  - state INICIAL; all counters 0.
  - medir = 0, distancia = 12'h000, nova_medida = 0, alarme = 0, erro_timeout = 0.
- States (db_estado code in parentheses):
  - INICIAL (0): idle. Go to DISPARA when ligar = 1.
  - DISPARA (1): medir = 1 for exactly one cycle; interval and watchdog counters cleared. Next state AGUARDA.
  - AGUARDA (2): watchdog and interval counters increment.
    - pronto_sensor = 1 → REGISTRA. If pronto and watchdog terminal count occur in the same cycle, pronto wins.
    - Watchdog reaches TIMEOUT_PRONTO-1 → FALHA.
  - REGISTRA (3): latch medida_sensor into distancia; evaluate alarm. Next state ATUALIZA.
  - ATUALIZA (4): nova_medida = 1 for one cycle. Next state ESPERA.
  - ESPERA (5): interval counter keeps running.
    - ligar = 0 → INICIAL.
    - Interval reaches PERIODO_MEDIDA-1 → DISPARA.
    - If the interval already expired during AGUARDA, go to DISPARA on the next cycle.
  - FALHA (F): set erro_timeout; distancia unchanged; alarme forced to 0. Next state ESPERA, so the system retries on the next period.
- erro_timeout clears only on reset or on a later successful REGISTRA.
- Alarm: BCD values compare correctly as unsigned binary. Without the optional feature, alarme = (medida_sensor < LIMIAR_BCD) at REGISTRA; it is held until the next REGISTRA or FALHA.
- pronto_sensor outside AGUARDA is ignored.
- ligar dropping during AGUARDA does not abort the measurement; it completes, then the FSM goes to INICIAL from ESPERA.
- Latency: pronto_sensor → distancia valid takes 1 cycle; nova_medida asserts 2 cycles after pronto_sensor.
- Counter widths = $clog2 of the respective parameter; counters saturate, never wrap.

Optional Feature:
- Macro: CONFIRMACAO_ALARME_EN.
- Defined: alarme sets only after 3 consecutive readings below LIMIAR_BCD, and clears only after 3 consecutive readings at or above it.
  - 2-bit run counter, reset by any opposite reading.
  - FALHA clears the run counter but holds alarme.
- Undefined: alarme follows each individual reading as described in Behaviour.

Decomposition:
- Package pkg_medicao: state encoding localparams (INICIAL..FALHA, 4-bit), BCD width constant (12), confirmation count (3).
- One natural sub-module: contador_intervalo, a parameterised up-counter with clear, enable, terminal-count output and saturation. It is instantiated twice (interval counter and watchdog).

Test Plan:
- Reset mid-AGUARDA → next cycle: db_estado = 0, medir = 0, distancia = 000, alarme = 0, erro_timeout = 0.
- ligar = 1; pronto_sensor with medida_sensor = 12'h123 five cycles after medir → distancia = 123 one cycle after pronto, nova_medida pulse, alarme = 0. Next medir exactly PERIODO_MEDIDA cycles after the first (test with reduced parameters: PERIODO 100, TIMEOUT 50).
- No pronto_sensor → erro_timeout = 1 at cycle 50, db_estado = F for one cycle, retry medir at cycle 100. A successful reading of 12'h050 then clears erro_timeout.
- Readings 015, 019, 025 without the macro → alarme 1, 1, 0. With CONFIRMACAO_ALARME_EN, readings 015, 015, 015 → alarme rises on the third; 025, 015 → alarme stays 1.
- pronto_sensor and watchdog terminal count in the same cycle → REGISTRA taken, erro_timeout stays 0.
- ligar dropped during AGUARDA → measurement completes, nova_medida pulses, FSM returns to INICIAL, no further medir.
